// File: rtl/mem_axi_rd_master_pkg.sv
// Shared types and constants for the AXI3 read master and its data FIFO.
package mem_axi_rd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bit positions inside done_err
  localparam int ERR_RRESP   = 0;
  localparam int ERR_RLAST   = 1;
  localparam int ERR_RID     = 2;
  localparam int ERR_ILLEGAL = 3;

endpackage

// File: rtl/mem_axi_rd_fifo.sv
// Synchronous FIFO holding accepted read beats until the client drains them.
module mem_axi_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags and guarded handshakes; the head is forced to zero when empty
  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = empty ? '0 : mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_axi_rd_master.sv
// AXI3 read master: one client burst at a time, beats buffered in a FIFO, protocol status on done.
module mem_axi_rd_master
  import mem_axi_rd_master_pkg::*;
#(
  parameter int ADD_ID_WIDTH = 4,
  parameter int ADD_WIDTH    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 4,
  parameter int BURST_SIZE   = 3,
  parameter int BURST_TYPE   = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADD_WIDTH-1:0]    req_addr,
  input  logic [BURST_LEN-1:0]    req_len,
  input  logic [BURST_SIZE-1:0]   req_size,
  input  logic [ADD_ID_WIDTH-1:0] req_id,
  output logic [ADD_ID_WIDTH-1:0] arid,
  output logic [ADD_WIDTH-1:0]    araddr,
  output logic [BURST_LEN-1:0]    arlen,
  output logic [BURST_SIZE-1:0]   arsize,
  output logic [BURST_TYPE-1:0]   arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ADD_ID_WIDTH-1:0] rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    done,
  output logic [3:0]              done_err
);

  localparam int SIZE_MAX = $clog2(DATA_WIDTH/8);
  localparam int FIFO_AW  = $clog2(FIFO_DEPTH);

  rd_state_t               state, state_next;
  logic [ADD_ID_WIDTH-1:0] lat_id;
  logic [ADD_WIDTH-1:0]    lat_addr;
  logic [BURST_LEN-1:0]    lat_len;
  logic [BURST_SIZE-1:0]   lat_size;
  logic [BURST_LEN-1:0]    beat_cnt;
  logic [3:0]              err_acc;
  logic [ADD_WIDTH:0]      req_bytes;
  logic [ADD_WIDTH:0]      req_end;
  logic                    req_illegal;
  logic                    r_hs;
  logic                    last_beat;
  logic                    term;
  logic [3:0]              beat_err;
  logic [FIFO_AW:0]        fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;

  // Request legality: beat size must fit the data bus and the burst must stay inside one 4KB page
  always_comb begin
    req_bytes   = ({{(ADD_WIDTH+1-BURST_LEN){1'b0}}, req_len} + (ADD_WIDTH+1)'(1)) << req_size;
    req_end     = {1'b0, req_addr} + req_bytes - (ADD_WIDTH+1)'(1);
    req_illegal = (req_size > BURST_SIZE'(SIZE_MAX)) ||
                  ((req_end >> 12) != ({1'b0, req_addr} >> 12));
  end

  // Per-beat protocol checks against the latched request
  always_comb begin
    r_hs                = rvalid && rready;
    last_beat           = (beat_cnt == lat_len);
    term                = rlast || last_beat;
    beat_err            = '0;
    beat_err[ERR_RRESP] = (rresp != RESP_OKAY);
    beat_err[ERR_RLAST] = (rlast != last_beat);
    beat_err[ERR_RID]   = (rid != lat_id);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    done       = 1'b0;
    done_err   = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_illegal ? ST_RESP : ST_ADDR;
      end
      ST_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = ST_DATA;
      end
      ST_DATA: begin
        rready = (fifo_count < (FIFO_AW+1)'(FIFO_DEPTH));
        if (rvalid && rready && term) state_next = ST_RESP;
      end
      ST_RESP: begin
        done       = 1'b1;
        done_err   = err_acc;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, request latch, beat counter and sticky error accumulator
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      lat_id   <= '0;
      lat_addr <= '0;
      lat_len  <= '0;
      lat_size <= '0;
      beat_cnt <= '0;
      err_acc  <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_id               <= req_id;
            lat_addr             <= req_addr;
            lat_len              <= req_len;
            lat_size             <= req_size;
            beat_cnt             <= '0;
            err_acc              <= '0;
            err_acc[ERR_ILLEGAL] <= req_illegal;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + BURST_LEN'(1);
            err_acc  <= err_acc | beat_err;
          end
        end
        ST_RESP: err_acc <= '0;
        default: ;
      endcase
    end
  end

  assign arid    = lat_id;
  assign araddr  = lat_addr;
  assign arlen   = lat_len;
  assign arsize  = lat_size;
  assign arburst = BURST_TYPE'(AXI_BURST_INCR);
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign out_valid = !fifo_empty;

  mem_axi_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_hs && !fifo_full),
    .din   ({rdata, term}),
    .pop   (out_ready),
    .dout  ({out_data, out_last}),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_axi_rd_master.sv
// Self-checking bench for mem_axi_rd_master with a behavioural AXI3 read slave and scoreboard queues.
module tb_mem_axi_rd_master;
  import mem_axi_rd_master_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [2:0]  req_size;
  logic [3:0]  req_id;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;
  logic [3:0]  done_err;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;
  int r_hs_count   = 0;
  int cur_mode     = 0;
  logic cur_illegal = 1'b0;
  logic pending_done = 1'b0;

  logic [32:0] exp_beats [$];
  logic [3:0]  exp_done  [$];
  logic [42:0] exp_ar    [$];

  // Slave state
  logic        s_busy;
  logic        slave_term_beat;
  logic [31:0] s_addr;
  logic [3:0]  s_len;
  logic [2:0]  s_size;
  logic [3:0]  s_id;
  int          s_mode;
  int          s_beat;
  int          s_nbeats;

  mem_axi_rd_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_size  (req_size),
    .req_id    (req_id),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arlock    (arlock),
    .arcache   (arcache),
    .arprot    (arprot),
    .arvalid   (arvalid),
    .arready   (arready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done),
    .done_err  (done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: every byte holds its address mod 256; a beat returns the aligned 32-bit word
  function automatic logic [31:0] beatWord(input logic [31:0] addr, input int size, input int k);
    logic [31:0] base;
    logic [7:0]  b;
    base = (k == 0) ? addr : (((addr >> size) << size) + (32'(k) << size));
    b    = base[7:0] & 8'hFC;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compare_cnt++;
    if (obs !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read slave: accepts AR when idle, then returns beats honouring rready; mode injects faults
  always @(posedge clk) begin : slave
    int k;
    if (!reset) begin
      s_busy          <= 1'b0;
      arready         <= 1'b0;
      rvalid          <= 1'b0;
      rlast           <= 1'b0;
      rdata           <= '0;
      rid             <= '0;
      rresp           <= '0;
      slave_term_beat <= 1'b0;
      s_beat          <= 0;
    end else if (!s_busy) begin
      arready <= 1'b1;
      rvalid  <= 1'b0;
      if (arvalid && arready) begin
        s_busy   <= 1'b1;
        arready  <= 1'b0;
        s_addr   <= araddr;
        s_len    <= arlen;
        s_size   <= arsize;
        s_id     <= arid;
        s_mode   <= cur_mode;
        s_beat   <= 0;
        s_nbeats <= (cur_mode == 1) ? 2 : int'(arlen) + 1;
      end
    end else if (!rvalid || rready) begin
      if (rvalid && (s_beat == s_nbeats - 1)) begin
        s_busy          <= 1'b0;
        rvalid          <= 1'b0;
        slave_term_beat <= 1'b0;
      end else begin
        k = rvalid ? s_beat + 1 : 0;
        s_beat          <= k;
        rvalid          <= 1'b1;
        rdata           <= beatWord(s_addr, int'(s_size), k);
        rid             <= (s_mode == 3) ? (s_id ^ 4'h1) : s_id;
        rresp           <= (s_mode == 2 && k == 0) ? RESP_SLVERR : RESP_OKAY;
        rlast           <= (s_mode == 1) ? (k == 1) : (s_mode == 4) ? 1'b0 : (k == int'(s_len));
        slave_term_beat <= (k == s_nbeats - 1);
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin : monitor
    logic [32:0] b;
    logic [42:0] a;
    logic [3:0]  d;
    if (reset) begin
      if (pending_done) begin
        checkOutput("done_latency", 64'(done), 64'd1);
        pending_done = 1'b0;
      end
      if (rvalid && rready) begin
        r_hs_count++;
        if (slave_term_beat) pending_done = 1'b1;
      end
      if (req_valid && req_ready && cur_illegal) pending_done = 1'b1;
      if (arvalid) begin
        if (exp_ar.size() == 0) checkOutput("ar_unexpected", 64'(arvalid), 64'd0);
        else if (arready) begin
          a = exp_ar.pop_front();
          checkOutput("ar_fields", 64'({arid, araddr, arlen, arsize}), 64'(a));
          checkOutput("ar_const", 64'({arburst, arlock, arcache, arprot}), 64'({2'b01, 2'b00, 4'h0, 3'h0}));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_beats.size() == 0) checkOutput("beat_unexpected", 64'(out_valid), 64'd0);
        else begin
          b = exp_beats.pop_front();
          checkOutput("out_beat", 64'({out_last, out_data}), 64'(b));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) checkOutput("done_unexpected", 64'(done), 64'd0);
        else begin
          d = exp_done.pop_front();
          checkOutput("done_err", 64'(done_err), 64'(d));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input int len, input int size,
                               input logic [3:0] id, input int mode);
    logic [63:0] end_a;
    logic        illegal;
    int          n;
    bit          accepted;
    end_a   = 64'(addr) + ((64'(len) + 64'd1) << size) - 64'd1;
    illegal = (size > 2) || ((64'(addr) >> 12) != (end_a >> 12));
    if (illegal) exp_done.push_back(4'b1000);
    else begin
      exp_ar.push_back({id, addr, 4'(len), 3'(size)});
      n = (mode == 1) ? 2 : len + 1;
      for (int k = 0; k < n; k++) exp_beats.push_back({k == n - 1, beatWord(addr, size, k)});
      case (mode)
        1:       exp_done.push_back(4'b0010);
        2:       exp_done.push_back(4'b0001);
        3:       exp_done.push_back(4'b0100);
        4:       exp_done.push_back(4'b0010);
        default: exp_done.push_back(4'b0000);
      endcase
    end
    cur_mode    = mode;
    cur_illegal = illegal;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = 4'(len);
    req_size  = 3'(size);
    req_id    = id;
    accepted  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) checkOutput("req_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_done.size() == 0 && exp_beats.size() == 0 && !pending_done) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) checkOutput("drain_timeout", 64'(exp_done.size() + exp_beats.size()), 64'd0);
    @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_size  = '0;
    req_id    = '0;
    out_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
    checkOutput("rst_rready", 64'(rready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_done", 64'({done, done_err}), 64'd0);
    checkOutput("rst_araddr", 64'(araddr), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] single and two-beat bursts");
    applyStimulus(32'h0, 0, 2, 4'h1, 0);
    waitIdle();
    applyStimulus(32'h3, 1, 1, 4'h2, 0);
    waitIdle();

    $display("[TB] backpressure");
    out_ready  = 1'b0;
    r_hs_count = 0;
    applyStimulus(32'h40, 7, 2, 4'h3, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("bp_beats_accepted", 64'(r_hs_count), 64'd4);
    checkOutput("bp_rready", 64'(rready), 64'd0);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_beats_pending", 64'(exp_beats.size()), 64'd8);
    @(posedge clk);
    #1 out_ready = 1'b1;
    waitIdle();

    $display("[TB] illegal requests");
    applyStimulus(32'hFF8, 3, 2, 4'h4, 0);
    waitIdle();
    applyStimulus(32'h100, 0, 3, 4'h5, 0);
    waitIdle();

    $display("[TB] protocol errors");
    applyStimulus(32'h80, 3, 2, 4'h6, 1);
    waitIdle();
    applyStimulus(32'h90, 1, 2, 4'h7, 2);
    waitIdle();
    applyStimulus(32'hA0, 1, 2, 4'h8, 3);
    waitIdle();
    applyStimulus(32'hB0, 2, 2, 4'h9, 4);
    waitIdle();

    $display("[TB] reset during data phase");
    out_ready = 1'b0;
    applyStimulus(32'h200, 7, 2, 4'hA, 0);
    repeat (12) @(posedge clk);
    #1 reset = 1'b0;
    exp_beats.delete();
    exp_done.delete();
    exp_ar.delete();
    pending_done = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_arvalid", 64'(arvalid), 64'd0);
    checkOutput("mid_rst_rready", 64'(rready), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_done", 64'(done), 64'd0);
    checkOutput("mid_rst_req_ready", 64'(req_ready), 64'd1);
    out_ready = 1'b1;
    applyStimulus(32'h300, 3, 2, 4'hB, 0);
    waitIdle();

    checkOutput("end_queues", 64'(exp_beats.size() + exp_done.size() + exp_ar.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/mem_axi_rd_master.md
Name: mem_axi_rd_master

Overview:
- AXI3 read master that sits directly upstream of mem_slave_top_module's AR/R channels.
- Accepts one burst request at a time from a client over a valid/ready interface, then drives the AR channel.
- Collects R beats into a small data FIFO that the client drains over a valid/ready stream.
- Checks protocol (rlast position, rresp, rid) and reports per-transaction status with a done pulse.

Parameters:
- ADD_ID_WIDTH, 4, arid/rid width.
- ADD_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, rdata width in bits; power of 2, minimum 8.
- BURST_LEN, 4, arlen width (AXI3).
- BURST_SIZE, 3, arsize width.
- BURST_TYPE, 2, arburst width.
- FIFO_DEPTH, 4, read-data FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high in IDLE only.
- req_addr  in  ADD_WIDTH  start byte address.
- req_len  in  BURST_LEN  beats minus 1.
- req_size  in  BURST_SIZE  log2 bytes per beat.
- req_id  in  ADD_ID_WIDTH  transaction id.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  per AXI3  read address fields.
- arvalid  out  1;  arready  in  1.
- rid  in  ADD_ID_WIDTH;  rdata  in  DATA_WIDTH;  rresp  in  2;  rlast  in  1;  rvalid  in  1;  rready  out  1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  client pop.
- out_data  out  DATA_WIDTH  head beat.
- out_last  out  1  head beat is final beat of its transaction.
- done  out  1  one-cycle completion pulse.
- done_err  out  4  status, valid when done=1: [0] rresp!=OKAY on any beat, [1] rlast mismatch, [2] rid mismatch, [3] illegal request (not issued).

Behaviour:
- Reset (reset==0 at posedge):
  - State IDLE.
  - arvalid=0, rready=0, done=0, done_err=0.
  - FIFO emptied, so out_valid=0; out_last=0.
  - AR fields 0.
  - req_ready=1 from the first cycle after reset is released.
  - Reset mid-transaction abandons it silently (the slave is reset together).
- Constant AR fields: arburst=INCR (2'b01), arlock=0, arcache=0, arprot=0.
- IDLE: on req_valid&&req_ready, latch the request.
  - Illegal request if req_size > log2(DATA_WIDTH/8), or if the burst crosses a 4KB boundary: addr[ADD_WIDTH-1:12] != end[ADD_WIDTH-1:12], where end = addr + ((len+1)<<size) - 1, computed in ADD_WIDTH+1 bits.
  - Illegal: go to RESP; no AR issued.
  - Legal: go to ADDR; arvalid=1 on the next cycle.
- ADDR: arvalid and all AR fields held stable until arready sampled high; then arvalid=0 and go to DATA. Unaligned start addresses are passed through unchanged.
- DATA:
  - rready = (FIFO count < FIFO_DEPTH), from the registered count. No push when full, even on a simultaneous pop.
  - Per accepted beat (rvalid&&rready):
    - push {rdata, term}; beat_cnt++.
    - OR errors into a sticky accumulator: rresp!=0 sets bit0; rid!=latched id sets bit2; rlast!=(beat_cnt==len) sets bit1.
  - term = rlast || (beat_cnt==len).
    - Early rlast terminates the transaction.
    - A missing rlast at the expected beat also terminates, with bit1 set; any later beats are not accepted in this transaction.
  - On the term beat, go to RESP.
- RESP: one cycle; done=1 with done_err = accumulator; accumulator cleared; next state IDLE. req_ready is 0 in RESP. Latency is fixed: the done pulse is exactly one cycle after the terminating beat handshake, or one cycle after request acceptance when the request is illegal.
- FIFO:
  - Pop on out_valid&&out_ready.
  - Drains independently of the state; new requests are accepted whatever the FIFO occupancy.
  - Beat order is preserved.
  - out_data/out_last are taken from the head entry and are stable while out_valid&&!out_ready.
- Width rules: beat_cnt is BURST_LEN bits and cannot wrap (at most 16 beats). The FIFO count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared param.v/axi_def.v: AX_SIZE_*/AX_LEN_* macros, AXI_BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR, done_err bit indices, state encodings.
- One sub-module: mem_axi_rd_fifo, a synchronous FIFO (DATA_WIDTH+1 bits wide, FIFO_DEPTH deep) with count, full and empty outputs.

Test Plan (DATA_WIDTH=32, memory slave preloaded with byte value = address mod 256):
- Single beat: req addr 0, len 0, size 2 → arlen=0, arsize=2, arburst=01; one out beat 0x03020100 with out_last=1; done=1, done_err=0000.
- Two beats: req addr 3, len 1, size 1 → arlen=1, arsize=1; two out beats with the slave's data in order; out_last=1 only on the second; done_err=0000.
- Backpressure: len 7, size 2, out_ready=0 → rready drops after 4 accepted beats. Raise out_ready after 20 cycles → all 8 beats delivered in order, exactly one out_last, done once.
- Illegal request: addr 0xFF8, len 3, size 2 → arvalid never asserted; done=1 one cycle after acceptance with done_err=1000. Also size 3 → done_err=1000.
- Protocol errors, using a stub slave:
  - rlast on beat 1 of a len-3 burst → 2 beats delivered, out_last on beat 1, done_err=0010.
  - rresp=SLVERR on beat 0 of a len-1 burst → 2 beats delivered, done_err=0001.
  - Wrong rid → done_err=0100.
- Reset mid-DATA: reset=0 for one cycle → next cycle arvalid=0, rready=0, out_valid=0, done=0, req_ready=1; a following request completes normally.
